// File: rtl/id_rob_mid_pkg.sv
// id_rob_mid shared definitions: payload width, field positions,
// and skid buffer state encoding.
package id_rob_mid_pkg;

    localparam int IDROB_PAYLOAD_W = 64;

    localparam int IDROB_SEG_PC_LSB    = 0;
    localparam int IDROB_SEG_PC_W      = 32;
    localparam int IDROB_SEG_DS_LSB    = 32;
    localparam int IDROB_SEG_OPGEN_LSB = 33;
    localparam int IDROB_SEG_OPGEN_W   = 8;
    localparam int IDROB_SEG_RD_LSB    = 41;
    localparam int IDROB_SEG_RD_W      = 5;
    localparam int IDROB_SEG_WE_LSB    = 46;
    localparam int IDROB_SEG_INFO_LSB  = 47;
    localparam int IDROB_SEG_INFO_W    = 17;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [IDROB_SEG_PC_W-1:0] idrob_pc(
        input logic [IDROB_PAYLOAD_W-1:0] p
    );
        return p[IDROB_SEG_PC_LSB +: IDROB_SEG_PC_W];
    endfunction

endpackage

// File: rtl/id_rob_mid_skid_buffer.sv
// Generic 2-entry valid/ready register with flush.
// in_ready depends only on registered state.
module id_rob_mid_skid_buffer
    import id_rob_mid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    skid_state_e state_q;
    skid_state_e state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic accept;
    logic fire;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    // Next state and register load selects.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !fire) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (fire && !accept) begin
                    state_d = ST_EMPTY;
                end else if (accept && fire) begin
                    load_main = 1'b1;
                end
            end
            ST_TWO: begin
                if (fire) begin
                    state_d        = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // State and payload registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/id_rob_mid.sv
// ID->ROB mid-stage: skid-buffered packet register plus
// delay-slot tracking fed back to ID.
module id_rob_mid
    import id_rob_mid_pkg::*;
#(
    parameter int PAYLOAD_W = IDROB_PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [PAYLOAD_W-1:0] id_payload,
    input  logic                 id_is_next_delayslot,
    output logic                 id_ready,
    output logic                 is_current_delayslot,
    output logic                 rob_valid,
    output logic [PAYLOAD_W-1:0] rob_payload,
    input  logic                 rob_ready
);

    logic ds_pending;
    logic accept;

    id_rob_mid_skid_buffer #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (id_valid),
        .in_data  (id_payload),
        .in_ready (id_ready),
        .out_valid(rob_valid),
        .out_data (rob_payload),
        .out_ready(rob_ready)
    );

    assign accept               = id_valid & id_ready;
    assign is_current_delayslot = ds_pending;

    // Delay-slot tag follows the latest accepted packet.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ds_pending <= 1'b0;
        end else if (accept) begin
            ds_pending <= id_is_next_delayslot;
        end
    end

endmodule

// File: tb/tb_id_rob_mid.sv
// Randomized + directed bench for id_rob_mid against a queue model.
module tb_id_rob_mid;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         id_valid = 1'b0;
    logic [W-1:0] id_payload = '0;
    logic         id_is_next_delayslot = 1'b0;
    logic         id_ready;
    logic         is_current_delayslot;
    logic         rob_valid;
    logic [W-1:0] rob_payload;
    logic         rob_ready = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    logic [W-1:0] mq[$];
    logic         m_ds = 1'b0;
    logic         m_zero = 1'b0;
    logic         started = 1'b0;

    always #5 clk = ~clk;

    id_rob_mid dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .id_valid            (id_valid),
        .id_payload          (id_payload),
        .id_is_next_delayslot(id_is_next_delayslot),
        .id_ready            (id_ready),
        .is_current_delayslot(is_current_delayslot),
        .rob_valid           (rob_valid),
        .rob_payload         (rob_payload),
        .rob_ready           (rob_ready)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%h expected=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO of at most two packets.
    always @(posedge clk) begin
        logic acc;
        logic fir;
        acc = id_valid && (mq.size() < 2);
        fir = (mq.size() > 0) && rob_ready;
        if (rst) begin
            mq.delete();
            m_ds = 1'b0;
            m_zero = 1'b1;
            started = 1'b1;
        end else if (flush) begin
            mq.delete();
            m_ds = 1'b0;
            if (acc) m_zero = 1'b0;
        end else begin
            if (fir) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(id_payload);
                m_ds = id_is_next_delayslot;
                m_zero = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("rob_valid", W'(rob_valid), W'(mq.size() != 0));
            chk("id_ready", W'(id_ready), W'(mq.size() < 2));
            chk("is_cur_ds", W'(is_current_delayslot), W'(m_ds));
            if (mq.size() != 0) chk("rob_payload", rob_payload, mq[0]);
            else if (m_zero) chk("rob_payload_rst", rob_payload, '0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] p, input logic ds);
        id_valid = 1'b1;
        id_payload = p;
        id_is_next_delayslot = ds;
    endtask

    initial begin
        step();
        rst = 1'b0;
        chk("rst_valid", W'(rob_valid), 0);
        chk("rst_ready", W'(id_ready), 1);
        chk("rst_ds", W'(is_current_delayslot), 0);
        chk("rst_payload", rob_payload, 0);

        rob_ready = 1'b1;
        push(64'hA1, 1'b0);
        step();
        chk("a1_valid", W'(rob_valid), 1);
        chk("a1_payload", rob_payload, 64'hA1);
        chk("a1_ready", W'(id_ready), 1);
        id_valid = 1'b0;
        step();

        for (int i = 1; i <= 8; i++) begin
            push(W'(i), 1'b0);
            step();
            chk("stream", rob_payload, W'(i));
            chk("stream_valid", W'(rob_valid), 1);
        end
        id_valid = 1'b0;
        step();

        rob_ready = 1'b0;
        push(64'h10, 1'b0);
        step();
        push(64'h11, 1'b0);
        step();
        chk("two_ready", W'(id_ready), 0);
        push(64'h12, 1'b0);
        step();
        chk("two_hold", rob_payload, 64'h10);
        rob_ready = 1'b1;
        step();
        chk("drain_11", rob_payload, 64'h11);
        step();
        chk("drain_12", rob_payload, 64'h12);
        id_valid = 1'b0;
        step();
        chk("drained", W'(rob_valid), 0);

        push(64'h20, 1'b1);
        step();
        chk("ds_set", W'(is_current_delayslot), 1);
        id_valid = 1'b0;
        rob_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ds_hold", W'(is_current_delayslot), 1);
        end
        rob_ready = 1'b1;
        push(64'h21, 1'b0);
        step();
        chk("ds_clear", W'(is_current_delayslot), 0);
        id_valid = 1'b0;
        step();

        rob_ready = 1'b0;
        push(64'h30, 1'b0);
        step();
        push(64'h31, 1'b1);
        step();
        chk("fl_ds_pre", W'(is_current_delayslot), 1);
        push(64'h32, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        id_valid = 1'b0;
        chk("fl_valid", W'(rob_valid), 0);
        chk("fl_ready", W'(id_ready), 1);
        chk("fl_ds", W'(is_current_delayslot), 0);
        rob_ready = 1'b1;
        step();
        chk("fl_gone", W'(rob_valid), 0);

        rob_ready = 1'b0;
        push(64'h40, 1'b1);
        step();
        id_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", W'(rob_valid), 0);
        chk("mrst_ready", W'(id_ready), 1);
        chk("mrst_ds", W'(is_current_delayslot), 0);
        chk("mrst_payload", rob_payload, 0);

        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 3) != 0);
            id_payload = {$urandom, $urandom};
            id_is_next_delayslot = $urandom_range(0, 1) == 1;
            rob_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 150) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        id_valid = 1'b0;
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
